// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the EX/MEM latch state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } exmem_state_t;

endpackage

// File: rtl/exmem_if.sv
// EX/MEM pipeline latch bundle: ID/EX-side inputs, latched outputs and the data-memory port.
interface exmem_if;
  import cpu_types_pkg::*;

  logic     en;
  logic     flush;

  word_t    npc_idex;
  word_t    rdat1_idex;
  word_t    rdat2_idex;
  word_t    imm_idex;
  word_t    portOut_idex;
  logic     rwen_idex;
  logic     memregSel_idex;
  logic     dren_idex;
  logic     dwen_idex;
  logic     halt_idex;
  regbits_t wSel_idex;

  word_t    npc_exmem;
  word_t    rdat1_exmem;
  word_t    imm_exmem;
  word_t    portOut_exmem;
  logic     rwen_exmem;
  logic     memregSel_exmem;
  logic     halt_exmem;
  regbits_t wSel_exmem;
  word_t    dload_exmem;

  logic     dREN;
  logic     dWEN;
  word_t    daddr;
  word_t    dstore;
  logic     dhit;
  word_t    dload;

  logic     mem_stall;

  modport emw (
    input  en, flush,
    input  npc_idex, rdat1_idex, rdat2_idex, imm_idex, portOut_idex,
    input  rwen_idex, memregSel_idex, dren_idex, dwen_idex, halt_idex, wSel_idex,
    output npc_exmem, rdat1_exmem, imm_exmem, portOut_exmem,
    output rwen_exmem, memregSel_exmem, halt_exmem, wSel_exmem, dload_exmem,
    output dREN, dWEN, daddr, dstore,
    input  dhit, dload,
    output mem_stall
  );

  modport tb (
    output en, flush,
    output npc_idex, rdat1_idex, rdat2_idex, imm_idex, portOut_idex,
    output rwen_idex, memregSel_idex, dren_idex, dwen_idex, halt_idex, wSel_idex,
    input  npc_exmem, rdat1_exmem, imm_exmem, portOut_exmem,
    input  rwen_exmem, memregSel_exmem, halt_exmem, wSel_exmem, dload_exmem,
    input  dREN, dWEN, daddr, dstore,
    output dhit, dload,
    input  mem_stall
  );

endinterface

// File: rtl/exmem_stage.sv
// EX/MEM pipeline latch with an embedded data-memory access FSM.
// A memory op occupies ACCESS until dhit, then DONE; non-memory ops pass in one cycle.
module exmem_stage
  import cpu_types_pkg::*;
(
  input logic   CLK,
  input logic   RST,
  exmem_if.emw  eif
);

  exmem_state_t state;
  word_t        rdat2_exmem;
  logic         dren_exmem;
  logic         dwen_exmem;
  logic         in_access;
  logic         cap;

  // Request/stall decode from registered state only; reset forces the request lines low.
  always_comb begin
    in_access     = (state == ACCESS) && !RST;
    cap           = eif.en && (state != ACCESS);
    eif.mem_stall = in_access;
    eif.dREN      = in_access && dren_exmem && !dwen_exmem;
    eif.dWEN      = in_access && dwen_exmem;
    eif.daddr     = eif.portOut_exmem;
    eif.dstore    = rdat2_exmem;
  end

  // Pipeline latch, sticky halt, load-data capture and access FSM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state               <= IDLE;
      eif.npc_exmem       <= '0;
      eif.rdat1_exmem     <= '0;
      rdat2_exmem         <= '0;
      eif.imm_exmem       <= '0;
      eif.portOut_exmem   <= '0;
      eif.rwen_exmem      <= 1'b0;
      eif.memregSel_exmem <= 1'b0;
      dren_exmem          <= 1'b0;
      dwen_exmem          <= 1'b0;
      eif.halt_exmem      <= 1'b0;
      eif.wSel_exmem      <= '0;
      eif.dload_exmem     <= '0;
    end else begin
      case (state)
        ACCESS: begin
          if (eif.dhit) begin
            state <= DONE;
            if (dren_exmem && !dwen_exmem) begin
              eif.dload_exmem <= eif.dload;
            end
          end
        end
        default: begin
          if (cap) begin
            if (eif.flush) begin
              eif.npc_exmem       <= '0;
              eif.rdat1_exmem     <= '0;
              rdat2_exmem         <= '0;
              eif.imm_exmem       <= '0;
              eif.portOut_exmem   <= '0;
              eif.rwen_exmem      <= 1'b0;
              eif.memregSel_exmem <= 1'b0;
              dren_exmem          <= 1'b0;
              dwen_exmem          <= 1'b0;
              eif.wSel_exmem      <= '0;
              state               <= IDLE;
            end else begin
              eif.npc_exmem       <= eif.npc_idex;
              eif.rdat1_exmem     <= eif.rdat1_idex;
              rdat2_exmem         <= eif.rdat2_idex;
              eif.imm_exmem       <= eif.imm_idex;
              eif.portOut_exmem   <= eif.portOut_idex;
              eif.rwen_exmem      <= eif.rwen_idex;
              eif.memregSel_exmem <= eif.memregSel_idex;
              dren_exmem          <= eif.dren_idex;
              dwen_exmem          <= eif.dwen_idex;
              eif.wSel_exmem      <= eif.wSel_idex;
              state               <= (eif.dren_idex || eif.dwen_idex) ? ACCESS : IDLE;
            end
            eif.halt_exmem <= eif.halt_exmem | (eif.halt_idex & ~eif.flush);
          end
        end
      endcase
    end
  end

endmodule
